muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations for the pipelined core. It sits beside the single-cycle ALU in the EX stage and is issued `MUL*`/`DIV*`/`REM*` instructions through a valid/ready handshake. The hazard unit stalls on `in_ready`/`out_valid`. The datapath is parametrised in width, and the unit is killable on pipeline flush.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_iter.sv | 34 +++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    logic s;
    case (op)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: s = 1'b1;
      MD_MULHU, MD_DIVU, MD_REMU:                 s = 1'b0;
      default:                                    s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shift-add multiply or restoring divide, purely combinational.
// acc_i holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] r_sub;

  assign hi    = acc_i[2*WIDTH-1:WIDTH];
  assign lo    = acc_i[WIDTH-1:0];
  assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb_i} : '0);
  assign r_sh  = {hi, lo[WIDTH-1]};
  assign ge    = (r_sh >= {1'b0, opb_i});
  // True difference is below the divisor, so the low WIDTH bits are exact.
  assign r_sub = r_sh[WIDTH-1:0] - opb_i;

  always_comb begin
    acc_o = {sum, lo[WIDTH-1:1]};
    if (div_i) begin
      acc_o = {(ge ? r_sub : r_sh[WIDTH-1:0]), lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush kill.
// Optional MULDIV_EARLY_OUT_EN: corner cases and zero-operand multiplies skip BUSY.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

  logic               sa_in, sb_in, dz_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo, rem, fin_res;

  assign sa_in    = op_a_signed(op) & rs1[WIDTH-1];
  assign sb_in    = op_b_signed(op) & rs2[WIDTH-1];
  assign a_mag_in = sa_in ? -rs1 : rs1;
  assign b_mag_in = sb_in ? -rs2 : rs2;
  assign dz_in    = is_div(op) && (rs2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic             ovf_in, early_in;
  logic [WIDTH-1:0] early_res;

  assign ovf_in   = is_div(op) && op_a_signed(op) &&
                    (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&rs2);
  assign early_in = dz_in || ovf_in || (!is_div(op) && ((rs1 == '0) || (rs2 == '0)));

  always_comb begin
    early_res = '0;
    if (dz_in) begin
      early_res = op[1] ? rs1 : '1;
    end else if (ovf_in) begin
      early_res = op[1] ? '0 : rs1;
    end
  end
`endif

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div_i (is_div(op_q)),
    .acc_i (acc_q),
    .opb_i (opb_q),
    .acc_o (acc_nxt)
  );

  assign prod_s = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
  assign quo    = acc_nxt[WIDTH-1:0];
  assign rem    = acc_nxt[2*WIDTH-1:WIDTH];

  // Signed overflow needs no substitution: |min|/1 with equal signs already yields rs1, rem 0.
  always_comb begin
    fin_res = '0;
    if (is_div(op_q)) begin
      if (op_q[1])    fin_res = sa_q ? -rem : rem;
      else if (dz_q)  fin_res = '1;
      else            fin_res = (sa_q ^ sb_q) ? -quo : quo;
    end else if (op_q == MD_MUL) begin
      fin_res = prod_s[WIDTH-1:0];
    end else begin
      fin_res = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !kill) begin
          op_d    = op;
          opb_d   = b_mag_in;
          acc_d   = {{WIDTH{1'b0}}, a_mag_in};
          sa_d    = sa_in;
          sb_d    = sb_in;
          dz_d    = dz_in;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_in) begin
            state_d  = DONE;
            result_d = early_res;
          end
`endif
        end
      end
      BUSY: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = fin_res;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor pops on handshake.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_C = 1;
`else
  localparam int LAT_C = 33;
`endif
  localparam int LAT_N = 33;

  logic        clk = 1'b0;
  logic        reset_n, kill, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: latency counts edges from the accept edge to the edge where out_valid is sampled.
  bit   seen = 1'b0;
  int   first_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output got=%h exp=none", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_latency"}, 32'(first_cyc - e.acc_cyc + 1), 32'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push, input string nm);
    exp_t t;
    bit   ok;
    ok = 1'b0;
    @(posedge clk); #1;
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        if (push) begin
          t.res = exp; t.acc_cyc = cyc + 1; t.lat = lat; t.name = nm;
          sb.push_back(t);
        end
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string nm);
    issue(o, a, b, exp, lat, 1'b1, nm);
    drain(nm);
    last_res = exp;
  endtask

  task automatic no_output(input string nm);
    bit saw;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    chk({nm, "_no_output"}, 32'(saw), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'h0);
    reset_n = 1'b1;

    run(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_N, "mul_7_m3");
    run(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_N, "mulhu_ff");
    run(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_N, "mulh_ff");
    run(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_N, "mulhsu_ff");
    run(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_N, "mulh_min_min");
    run(MD_MULHU,  32'h80000000, 32'd2,        32'h00000001, LAT_N, "mulhu_carry");
    run(MD_DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, LAT_N, "div_m20_6");
    run(MD_REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, LAT_N, "rem_m20_6");
    run(MD_DIV,    32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, LAT_N, "div_20_m6");
    run(MD_REM,    32'd20,       32'hFFFFFFFA, 32'h00000002, LAT_N, "rem_20_m6");
    run(MD_DIVU,   32'd100,      32'd7,        32'd14,       LAT_N, "divu_100_7");
    run(MD_REMU,   32'd100,      32'd7,        32'd2,        LAT_N, "remu_100_7");
    run(MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_C, "divu_by_zero");
    run(MD_REM,    32'd5,        32'd0,        32'd5,        LAT_C, "rem_by_zero");
    run(MD_DIV,    32'hFFFFFFF6, 32'd0,        32'hFFFFFFFF, LAT_C, "div_neg_by_zero");
    run(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_C, "div_overflow");
    run(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_C, "rem_overflow");
    run(MD_MUL,    32'd0,        32'h12345678, 32'h00000000, LAT_C, "mul_zero");

    // Consumer stalls five cycles in DONE.
    out_ready = 1'b0;
    issue(MD_MUL, 32'd3, 32'd5, 32'd15, LAT_N, 1'b1, "mul_hold");
    for (int i = 0; i < 60 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", result, 32'd15);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    drain("mul_hold");
    last_res = 32'd15;

    // Kill at the tenth BUSY cycle.
    issue(MD_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0, "kill_busy");
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_in_ready", 32'(in_ready), 32'd1);
    chk("kill_out_valid", 32'(out_valid), 32'd0);
    chk("kill_result_held", result, last_res);
    no_output("kill_busy");

    // Kill together with a request: nothing is accepted.
    @(posedge clk); #1;
    op = MD_MUL; rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_req_in_ready", 32'(in_ready), 32'd1);
    no_output("kill_req");

    // Reset mid-BUSY.
    issue(MD_MUL, 32'd3, 32'd5, 32'd0, 0, 1'b0, "reset_busy");
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy_result", result, 32'h0);
    reset_n = 1'b1;
    no_output("reset_busy");

    run(MD_REMU, 32'd17, 32'd5, 32'd2, LAT_N, "post_reset_remu");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
